// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential 4-digit BCD to 14-bit binary converter.
// Reverse double-dabble: each CONV cycle shifts the combined register right by
// one and subtracts 3 from every BCD nibble that reaches 8 or more. After 14
// shifts the low 14 bits hold the binary value.
//
// state | meaning
// IDLE  | waiting for start
// CONV  | shifting, one bit per clock (14 cycles)
// FIN   | one-cycle done pulse; out/error valid; start may be re-accepted here
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       thuns,
    input  logic [3:0]       huns,
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] out
);

    localparam int SREG_W = 4 * DIGITS + WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SREG_W-1:0]   sreg_q, sreg_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic                error_q, error_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [SREG_W-1:0]   t_corr;
    logic                digit_bad;

    // One shift step: shift right, then correct every BCD nibble that is >= 8.
    always_comb begin
        t_corr = {1'b0, sreg_q[SREG_W-1:1]};
        for (int i = 0; i < DIGITS; i++) begin
            if (t_corr[WIDTH + 4*i +: 4] >= 4'd8) begin
                t_corr[WIDTH + 4*i +: 4] = t_corr[WIDTH + 4*i +: 4] - 4'd3;
            end
        end
    end

    // Any nibble above 9 makes the request invalid; no conversion is run.
    always_comb begin
        digit_bad = (thuns > 4'd9) | (huns > 4'd9) | (tens > 4'd9) | (ones > 4'd9);
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        error_d = error_q;

        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (digit_bad) begin
                        state_d = ST_FIN;
                        error_d = 1'b1;
                        out_d   = '0;
                    end else begin
                        state_d = ST_CONV;
                        sreg_d  = {thuns, huns, tens, ones, {WIDTH{1'b0}}};
                        cnt_d   = 4'(WIDTH);
                        error_d = 1'b0;
                    end
                end
            end
            ST_CONV: begin
                // start is ignored while converting
                sreg_d = t_corr;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    out_d   = t_corr[WIDTH-1:0];
                    state_d = ST_FIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered so they change in step with the state.
        busy_d = (state_d == ST_CONV);
        done_d = (state_d == ST_FIN);
    end

    // State, datapath and status registers; reset aborts any conversion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            error_q <= error_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;
    assign out   = out_q;

endmodule
